// File: rtl/mux_arbiter2.sv
// mux_arbiter2: two-requester round-robin arbiter that owns a 2:1 mux path.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   req0, req1   requests for the mux path
//   w0, w1       data from requester 0 / requester 1
//   gnt0, gnt1   registered grants (never both high)
//   s            registered mux select (0 -> w0, 1 -> w1), held while idle
//   f            registered mux output, one cycle behind the grant state
//   f_vld        f carries granted data this cycle
//
// state | meaning
// IDLE  | no grant; path parked, f forced to 0
// G0    | requester 0 owns the path
// G1    | requester 1 owns the path
//
// Under contention a grant lasts MAX_HOLD cycles (legal 1..15) before the
// path is handed to the waiting requester. A lone requester keeps the grant
// indefinitely; hold_cnt simply saturates.

module mux_arbiter2 #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic w0,
   input  logic w1,
   output logic gnt0,
   output logic gnt1,
   output logic s,
   output logic f,
   output logic f_vld
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      G0   = 2'd1,
      G1   = 2'd2
   } state_t;

   localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

   state_t     state;
   state_t     state_nxt;
   logic       last;
   logic [3:0] hold_cnt;
   logic       hold_done;

   assign hold_done = (hold_cnt == HOLD_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req0 && req1)
               // last=1 after reset, so the first contention goes to requester 0
               state_nxt = last ? G0 : G1;
            else if (req0)
               state_nxt = G0;
            else if (req1)
               state_nxt = G1;
            else
               state_nxt = IDLE;
         end
         G0: begin
            if (!req0)
               state_nxt = req1 ? G1 : IDLE;
            else if (req1 && hold_done)
               state_nxt = G1;
            else
               state_nxt = G0;
         end
         G1: begin
            if (!req1)
               state_nxt = req0 ? G0 : IDLE;
            else if (req0 && hold_done)
               state_nxt = G0;
            else
               state_nxt = G1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         hold_cnt <= 4'd0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         s        <= 1'b0;
         f        <= 1'b0;
         f_vld    <= 1'b0;
      end else begin
         state <= state_nxt;
         gnt0  <= (state_nxt == G0);
         gnt1  <= (state_nxt == G1);

         // hold_cnt restarts on every fresh entry to a grant state, including
         // a direct G0<->G1 handoff.
         if (state_nxt == G0 && state != G0) begin
            last     <= 1'b0;
            hold_cnt <= 4'd0;
         end else if (state_nxt == G1 && state != G1) begin
            last     <= 1'b1;
            hold_cnt <= 4'd0;
         end else if (state_nxt != IDLE && hold_cnt != 4'hF) begin
            hold_cnt <= hold_cnt + 4'd1;
         end

         if (state_nxt == G0)
            s <= 1'b0;
         else if (state_nxt == G1)
            s <= 1'b1;

         // Data follows the grant state that was current during this cycle.
         case (state)
            G0:      f <= w0;
            G1:      f <= w1;
            default: f <= 1'b0;
         endcase
         f_vld <= (state != IDLE);
      end
   end

endmodule

// File: tb/tb_mux_arbiter2.sv
// Bench for mux_arbiter2: two instances (MAX_HOLD=4 and MAX_HOLD=1) share the
// stimulus; a behavioural model predicts each cycle's outputs, the prediction
// is queued when inputs are driven and popped after the clock edge.

module tb_mux_arbiter2;

   logic clk;
   logic rst_n;
   logic req0, req1, w0, w1;
   logic gnt0_a, gnt1_a, s_a, f_a, f_vld_a;
   logic gnt0_b, gnt1_b, s_b, f_b, f_vld_b;

   int n_chk;
   int n_pass;

   logic [9:0] sb_q[$];

   int         m_state[2];
   logic       m_last[2];
   int         m_hold[2];
   logic       m_s[2];
   int         m_mh[2];

   mux_arbiter2 #(.MAX_HOLD(4)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .w0(w0), .w1(w1),
      .gnt0(gnt0_a), .gnt1(gnt1_a), .s(s_a), .f(f_a), .f_vld(f_vld_a)
   );

   mux_arbiter2 #(.MAX_HOLD(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .w0(w0), .w1(w1),
      .gnt0(gnt0_b), .gnt1(gnt1_b), .s(s_b), .f(f_b), .f_vld(f_vld_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = 0;
         m_last[k]  = 1'b1;
         m_hold[k]  = 0;
         m_s[k]     = 1'b0;
      end
   endtask

   // Returns {gnt0, gnt1, s, f, f_vld} expected after the next edge.
   task automatic model_step(input int k, input logic r0, input logic r1,
                             input logic x0, input logic x1, output logic [4:0] e);
      int   ns;
      logic fe;
      logic ve;
      ns = m_state[k];
      if (m_state[k] == 0) begin
         if (r0 && r1)  ns = m_last[k] ? 1 : 2;
         else if (r0)   ns = 1;
         else if (r1)   ns = 2;
         else           ns = 0;
      end else if (m_state[k] == 1) begin
         if (!r0)                                  ns = r1 ? 2 : 0;
         else if (r1 && m_hold[k] == m_mh[k] - 1)  ns = 2;
         else                                      ns = 1;
      end else begin
         if (!r1)                                  ns = r0 ? 1 : 0;
         else if (r0 && m_hold[k] == m_mh[k] - 1)  ns = 1;
         else                                      ns = 2;
      end
      fe = (m_state[k] == 1) ? x0 : (m_state[k] == 2) ? x1 : 1'b0;
      ve = (m_state[k] != 0);
      if (ns != 0 && ns != m_state[k]) begin
         m_hold[k] = 0;
         m_last[k] = (ns == 2);
      end else if (ns != 0 && m_hold[k] < 15) begin
         m_hold[k] = m_hold[k] + 1;
      end
      if (ns == 1) m_s[k] = 1'b0;
      if (ns == 2) m_s[k] = 1'b1;
      m_state[k] = ns;
      e = {(ns == 1), (ns == 2), m_s[k], fe, ve};
   endtask

   task automatic step(input logic r0, input logic r1, input logic x0, input logic x1);
      logic [4:0] ea, eb;
      logic [9:0] got;
      @(negedge clk);
      req0 = r0; req1 = r1; w0 = x0; w1 = x1;
      model_step(0, r0, r1, x0, x1, ea);
      model_step(1, r0, r1, x0, x1, eb);
      sb_q.push_back({ea, eb});
      @(posedge clk);
      #1;
      got = sb_q.pop_front();
      check("hold4_outs", {27'd0, gnt0_a, gnt1_a, s_a, f_a, f_vld_a}, {27'd0, got[9:5]});
      check("hold1_outs", {27'd0, gnt0_b, gnt1_b, s_b, f_b, f_vld_b}, {27'd0, got[4:0]});
      check("gnt_excl", {30'd0, gnt0_a & gnt1_a, gnt0_b & gnt1_b}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [11:0] trace;
   int          hold_cnt_seen;

   initial begin
      n_chk = 0;
      n_pass = 0;
      m_mh[0] = 4;
      m_mh[1] = 1;
      req0 = 1'b0; req1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #12;
      check("reset_outs", {27'd0, gnt0_a, gnt1_a, s_a, f_a, f_vld_a}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // lone requester 0 with w0=1, held well past saturation
      hold_cnt_seen = 0;
      for (int i = 0; i < 22; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         if (gnt0_a) hold_cnt_seen++;
         if (i == 1) check("r0_f_after2", {30'd0, f_a, f_vld_a}, 32'd3);
      end
      check("r0_held", hold_cnt_seen, 22);

      // contention from reset: G0 x4, G1 x4, G0 x4
      do_reset();
      trace = '0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b1);
         trace[11 - i] = gnt0_a;
      end
      check("rr_hold4", {20'd0, trace}, {20'd0, 12'b1111_0000_1111});

      // G1 with req0 waiting, drop req1 -> direct handoff to G0
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("handoff_g0", {29'd0, gnt0_a, gnt1_a, s_a}, 32'b100);

      // G0 released with no other request -> IDLE, s parked at 0
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("idle_park", {28'd0, gnt0_a, s_a, f_a, f_vld_a}, 32'd0);

      // same-cycle swap: req0 drops while req1 rises
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("swap_g1", {30'd0, gnt1_a, s_a}, 32'd3);

      // data sweep in G0 then G1
      for (int v = 0; v < 5; v++) step(1'b1, 1'b0, v[0], v[1]);
      for (int v = 0; v < 5; v++) step(1'b0, 1'b1, v[0], v[1]);

      // asynchronous reset between edges while in G1
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_a", {27'd0, gnt0_a, gnt1_a, s_a, f_a, f_vld_a}, 32'd0);
      check("async_rst_b", {27'd0, gnt0_b, gnt1_b, s_b, f_b, f_vld_b}, 32'd0);
      model_reset();
      @(negedge clk);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("post_rst_g0", {30'd0, gnt0_a, gnt1_a}, 32'd2);

      // random traffic
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
